// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD DAT FIFO sequencer.
package sd_dat_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TX_POP,
    TX_PUSH,
    RX_WORD,
    BLK_WAIT,
    DONE
  } state_e;

  localparam logic DIR_WRITE = 1'b1;
  localparam logic DIR_READ  = 1'b0;

  // A block size field of zero selects the standard SD block length.
  localparam int DEFAULT_BLOCK_BYTES = 512;

endpackage

// File: rtl/dat_xfer_counter.sv
// Word down-counter and block up-counter for one DAT transfer.
// word_last_o flags the final word of a block; blk_last_o flags that the
// next completed block is the last one of the transfer.
module dat_xfer_counter #(
  parameter int WORD_W   = 12,
  parameter int BLKCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                word_load_i,
  input  logic [WORD_W-1:0]   word_load_val_i,
  input  logic                word_dec_i,
  input  logic                blk_clr_i,
  input  logic                blk_inc_i,
  input  logic [BLKCNT_W-1:0] blk_total_i,
  output logic                word_last_o,
  output logic [BLKCNT_W-1:0] blk_cnt_o,
  output logic                blk_last_o
);

  logic [WORD_W-1:0]   word_q;
  logic [BLKCNT_W-1:0] blk_q;

  // Words left in the current block; never wraps below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             word_q <= '0;
    else if (word_load_i)                  word_q <= word_load_val_i;
    else if (word_dec_i && word_q != '0)   word_q <= word_q - 1'b1;
  end

  // Blocks completed with good CRC since the last start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          blk_q <= '0;
    else if (blk_clr_i) blk_q <= '0;
    else if (blk_inc_i) blk_q <= blk_q + 1'b1;
  end

  assign word_last_o = (word_q == WORD_W'(1));
  assign blk_cnt_o   = blk_q;
  assign blk_last_o  = ((blk_q + BLKCNT_W'(1)) == blk_total_i);

endmodule

// File: rtl/dat_fifo_ctrl.sv
// SD DAT-line transfer sequencer between the data FIFO and the DAT phy.
// Write direction pops FIFO words into the serializer; read direction
// pushes deserialized words into the FIFO and stalls the card clock on full.
// Optional CRC-status watchdog: define DAT_FIFO_CTRL_TIMEOUT_EN.
module dat_fifo_ctrl
  import sd_dat_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BLKSZ_W        = 12,
  parameter int BLKCNT_W       = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_in,
  input  logic                dir_in,
  input  logic [BLKSZ_W-1:0]  block_size_in,
  input  logic [BLKCNT_W-1:0] block_count_in,
  input  logic                fifo_empty_in,
  input  logic                fifo_full_in,
  output logic                fifo_read_en_out,
  output logic                fifo_write_en_out,
  input  logic                phy_tx_ready_in,
  output logic                phy_tx_valid_out,
  input  logic                phy_rx_valid_in,
  output logic                phy_rx_ack_out,
  input  logic                phy_block_done_in,
  input  logic                phy_crc_ok_in,
  output logic                clk_stop_out,
  output logic                busy_out,
  output logic                done_out,
  output logic                error_out,
  output logic [BLKCNT_W-1:0] blocks_done_out
);

  // Word counter must hold 512 (default block) even for narrow size fields.
  localparam int WORD_W = (BLKSZ_W > 10) ? BLKSZ_W : 10;
  localparam logic [WORD_W-1:0] BPW = WORD_W'(DATA_WIDTH / 8);

  state_e              state_q, state_d;
  logic                dir_q, dir_d;
  logic [BLKSZ_W-1:0]  size_q, size_d;
  logic [BLKCNT_W-1:0] count_q, count_d;
  logic                error_q, error_d;

  logic                word_load, word_dec, blk_clr, blk_inc;
  logic                word_last, blk_last, timeout;
  logic [WORD_W-1:0]   blk_bytes, words_per_blk;

  // ceil(bytes / bytes-per-word) without a wider intermediate sum.
  assign blk_bytes     = (size_q == '0) ? WORD_W'(DEFAULT_BLOCK_BYTES) : WORD_W'(size_q);
  assign words_per_blk = (blk_bytes / BPW)
                       + {{(WORD_W-1){1'b0}}, ((blk_bytes % BPW) != '0)};

`ifdef DAT_FIFO_CTRL_TIMEOUT_EN
  logic [15:0] wd_q;

  // Watchdog runs only in BLK_WAIT; held at zero elsewhere so entry restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    wd_q <= '0;
    else if (state_q != BLK_WAIT) wd_q <= '0;
    else                          wd_q <= wd_q + 16'd1;
  end

  assign timeout = (state_q == BLK_WAIT) && (wd_q == 16'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out; a negative limit is meaningless so this folds to 0.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  dat_xfer_counter #(.WORD_W(WORD_W), .BLKCNT_W(BLKCNT_W)) u_cnt (
    .clk             (clk),
    .reset           (reset),
    .word_load_i     (word_load),
    .word_load_val_i (words_per_blk),
    .word_dec_i      (word_dec),
    .blk_clr_i       (blk_clr),
    .blk_inc_i       (blk_inc),
    .blk_total_i     (count_q),
    .word_last_o     (word_last),
    .blk_cnt_o       (blocks_done_out),
    .blk_last_o      (blk_last)
  );

  // State and latched transfer parameters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_READ;
      size_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      size_q  <= size_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Next-state, counter controls and FIFO/phy handshakes.
  always_comb begin
    state_d           = state_q;
    dir_d             = dir_q;
    size_d            = size_q;
    count_d           = count_q;
    error_d           = error_q;
    word_load         = 1'b0;
    word_dec          = 1'b0;
    blk_clr           = 1'b0;
    blk_inc           = 1'b0;
    fifo_read_en_out  = 1'b0;
    fifo_write_en_out = 1'b0;
    phy_rx_ack_out    = 1'b0;
    phy_tx_valid_out  = 1'b0;
    clk_stop_out      = 1'b0;
    case (state_q)
      IDLE: if (start_in) begin
        error_d = 1'b0;
        blk_clr = 1'b1;
        dir_d   = dir_in;
        size_d  = block_size_in;
        count_d = block_count_in;
        state_d = (block_count_in == '0) ? DONE : LOAD;
      end
      LOAD: begin
        word_load = 1'b1;
        state_d   = (dir_q == DIR_WRITE) ? TX_POP : RX_WORD;
      end
      TX_POP: if (!fifo_empty_in && phy_tx_ready_in) begin
        fifo_read_en_out = 1'b1;
        state_d          = TX_PUSH;
      end
      TX_PUSH: begin
        phy_tx_valid_out = 1'b1;
        word_dec         = 1'b1;
        state_d          = word_last ? BLK_WAIT : TX_POP;
      end
      RX_WORD: begin
        clk_stop_out = phy_rx_valid_in && fifo_full_in;
        if (phy_rx_valid_in && !fifo_full_in) begin
          fifo_write_en_out = 1'b1;
          phy_rx_ack_out    = 1'b1;
          word_dec          = 1'b1;
          if (word_last) state_d = BLK_WAIT;
        end
      end
      BLK_WAIT: begin
        if (phy_block_done_in) begin
          if (phy_crc_ok_in) begin
            blk_inc = 1'b1;
            state_d = blk_last ? DONE : LOAD;
          end else begin
            error_d = 1'b1;
            state_d = DONE;
          end
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_out  = (state_q != IDLE) && (state_q != DONE);
  assign done_out  = (state_q == DONE);
  assign error_out = error_q;

endmodule

// File: tb/tb_dat_fifo_ctrl.sv
// Directed bench for dat_fifo_ctrl with behavioural FIFO/phy environment
// and a per-cycle protocol checker.
module tb_dat_fifo_ctrl;

  localparam int DW  = 32;
  localparam int BSW = 12;
  localparam int BCW = 16;
`ifdef DAT_FIFO_CTRL_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic           clk = 1'b0;
  logic           reset, start_in, dir_in;
  logic [BSW-1:0] block_size_in;
  logic [BCW-1:0] block_count_in;
  logic           fifo_empty_in, fifo_full_in, fifo_read_en_out, fifo_write_en_out;
  logic           phy_tx_ready_in, phy_tx_valid_out, phy_rx_valid_in, phy_rx_ack_out;
  logic           phy_block_done_in, phy_crc_ok_in;
  logic           clk_stop_out, busy_out, done_out, error_out;
  logic [BCW-1:0] blocks_done_out;

  always #5 clk = ~clk;

  dat_fifo_ctrl #(.DATA_WIDTH(DW), .BLKSZ_W(BSW), .BLKCNT_W(BCW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start_in(start_in), .dir_in(dir_in),
    .block_size_in(block_size_in), .block_count_in(block_count_in),
    .fifo_empty_in(fifo_empty_in), .fifo_full_in(fifo_full_in),
    .fifo_read_en_out(fifo_read_en_out), .fifo_write_en_out(fifo_write_en_out),
    .phy_tx_ready_in(phy_tx_ready_in), .phy_tx_valid_out(phy_tx_valid_out),
    .phy_rx_valid_in(phy_rx_valid_in), .phy_rx_ack_out(phy_rx_ack_out),
    .phy_block_done_in(phy_block_done_in), .phy_crc_ok_in(phy_crc_ok_in),
    .clk_stop_out(clk_stop_out), .busy_out(busy_out), .done_out(done_out),
    .error_out(error_out), .blocks_done_out(blocks_done_out)
  );

  int checks = 0, errors = 0;
  int tot_re = 0, tot_txv = 0, tot_we = 0, tot_stop = 0, tot_done = 0, cyc = 0;
  int s_re, s_txv, s_we, s_stop, s_done;
  int last_txv_cyc = 0, done_cyc = 0;
  logic prev_re = 1'b0;

  // Environment: FIFO occupancy, pending rx words, full window, block-done responder.
  int fifo_words = 0, rx_pending = 0, wpb_env = 0, blk_words = 0;
  int full_after = 0, full_len = 0, full_cnt = 0, bd_dly = 0, blk_idx = 0;
  logic [15:0] crc_plan = '0;
  bit bd_en = 1'b0;

  // Words in one block from the byte count: ceil(bytes / bytes-per-word).
  function automatic int wpb(input int size);
    int bytes;
    bytes = (size == 0) ? 512 : size;
    return (bytes + DW/8 - 1) / (DW/8);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle protocol checks, sampled mid-cycle.
  task automatic cycle_check();
    if (reset) begin
      prev_re = 1'b0;
      return;
    end
    chk("txv_follows_pop", int'(phy_tx_valid_out), int'(prev_re));
    if (fifo_read_en_out) chk("pop_allowed", int'(!fifo_empty_in && phy_tx_ready_in), 1);
    chk("ack_eq_push", int'(phy_rx_ack_out), int'(fifo_write_en_out));
    if (fifo_write_en_out) chk("push_allowed", int'(phy_rx_valid_in && !fifo_full_in), 1);
    if (clk_stop_out) chk("stop_cond", int'(phy_rx_valid_in && fifo_full_in), 1);
    if (done_out) chk("done_not_busy", int'(busy_out), 0);
    tot_re   += int'(fifo_read_en_out);
    tot_txv  += int'(phy_tx_valid_out);
    tot_we   += int'(fifo_write_en_out);
    tot_stop += int'(clk_stop_out);
    tot_done += int'(done_out);
    if (phy_tx_valid_out) last_txv_cyc = cyc;
    if (done_out) done_cyc = cyc;
    prev_re = fifo_read_en_out;
  endtask

  task automatic tick();
    logic re, we, txv;
    @(negedge clk);
    cycle_check();
    re = fifo_read_en_out; we = fifo_write_en_out; txv = phy_tx_valid_out;
    @(posedge clk);
    cyc++;
    #1;
    phy_block_done_in = 1'b0;
    phy_crc_ok_in     = 1'b0;
    if (!reset) begin
      if (re && fifo_words > 0) fifo_words--;
      if (we && rx_pending > 0) rx_pending--;
      if (txv || we) blk_words++;
      if (full_cnt > 0) full_cnt--;
      if (we && full_after > 0 && blk_words == full_after) begin
        full_cnt = full_len; full_after = 0;
      end
      if (bd_dly > 0) begin
        bd_dly--;
        if (bd_dly == 0) begin
          phy_block_done_in = 1'b1;
          phy_crc_ok_in     = crc_plan[blk_idx];
          blk_idx++;
        end
      end
      if (wpb_env > 0 && blk_words == wpb_env) begin
        blk_words = 0;
        if (bd_en) bd_dly = 2;
      end
    end
    fifo_empty_in   = (fifo_words == 0);
    phy_rx_valid_in = (rx_pending > 0);
    fifo_full_in    = (full_cnt > 0);
  endtask

  task automatic start_xfer(input logic dir, input int size, input int count,
                            input int fifo, input int rx, input logic [15:0] plan,
                            input bit bden, input int fa, input int flen);
    fifo_words = fifo; rx_pending = rx; wpb_env = wpb(size); blk_words = 0;
    full_after = fa; full_len = flen; full_cnt = 0; bd_dly = 0; blk_idx = 0;
    crc_plan = plan; bd_en = bden;
    fifo_empty_in = (fifo == 0); phy_rx_valid_in = (rx > 0); fifo_full_in = 1'b0;
    s_re = tot_re; s_txv = tot_txv; s_we = tot_we; s_stop = tot_stop; s_done = tot_done;
    dir_in = dir; block_size_in = BSW'(size); block_count_in = BCW'(count);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (tot_done == s_done && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", int'(tot_done > s_done), 1);
  endtask

  // Post-transfer scoreboard: counts derived from block size and count.
  task automatic finish_xfer(input string nm, input logic dir, input int words,
                             input int blocks, input int err);
    repeat (3) tick();
    chk({nm, "_done_pulses"}, tot_done - s_done, 1);
    chk({nm, "_busy"}, int'(busy_out), 0);
    chk({nm, "_error"}, int'(error_out), err);
    chk({nm, "_blocks"}, int'(blocks_done_out), blocks);
    chk({nm, "_words"}, dir ? (tot_re - s_re) : (tot_we - s_we), words);
    chk({nm, "_txv_eq_pops"}, tot_txv - s_txv, tot_re - s_re);
  endtask

  initial begin
    reset = 1'b1; start_in = 1'b0; dir_in = 1'b0; block_size_in = '0; block_count_in = '0;
    fifo_empty_in = 1'b1; fifo_full_in = 1'b0; phy_tx_ready_in = 1'b1;
    phy_rx_valid_in = 1'b0; phy_block_done_in = 1'b0; phy_crc_ok_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_error", int'(error_out), 0);
    chk("rst_blocks", int'(blocks_done_out), 0);
    chk("rst_strobes", int'({fifo_read_en_out, fifo_write_en_out, phy_tx_valid_out,
                             phy_rx_ack_out, clk_stop_out}), 0);
    reset = 1'b0;
    repeat (2) tick();

    // Write, 8-byte blocks (2 words), 2 blocks, good CRC.
    start_xfer(1'b1, 8, 2, 4, 0, 16'h0003, 1'b1, 0, 0);
    wait_done(200);
    chk("t1_pops_literal", tot_re - s_re, 4);
    finish_xfer("t1", 1'b1, wpb(8) * 2, 2, 0);

    // Read, 16 bytes, 1 block, FIFO full for 5 cycles after the 2nd word.
    start_xfer(1'b0, 16, 1, 0, 4, 16'h0001, 1'b1, 2, 5);
    wait_done(200);
    chk("t2_stop_cycles", tot_stop - s_stop, 5);
    chk("t2_push_literal", tot_we - s_we, 4);
    finish_xfer("t2", 1'b0, wpb(16), 1, 0);

    // Write, 3 blocks, CRC bad on block 2.
    start_xfer(1'b1, 8, 3, 6, 0, 16'h0001, 1'b1, 0, 0);
    wait_done(300);
    finish_xfer("t3", 1'b1, 4, 1, 1);
    repeat (5) tick();
    chk("t3_idle_no_pop", tot_re - s_re, 4);
    chk("t3_error_sticky", int'(error_out), 1);

    // Zero block count: straight to DONE, start clears the sticky error.
    start_xfer(1'b1, 8, 0, 0, 0, 16'h0000, 1'b1, 0, 0);
    wait_done(20);
    finish_xfer("t4", 1'b1, 0, 0, 0);

    // Block size 0 means 512 bytes = 128 words.
    start_xfer(1'b1, 0, 1, 128, 0, 16'h0001, 1'b1, 0, 0);
    wait_done(1000);
    chk("t5_pops_literal", tot_re - s_re, 128);
    finish_xfer("t5", 1'b1, wpb(0), 1, 0);

    // Read, 5-byte blocks round up to 2 words, 2 blocks.
    start_xfer(1'b0, 5, 2, 0, 4, 16'h0003, 1'b1, 0, 0);
    wait_done(200);
    finish_xfer("t6", 1'b0, 4, 2, 0);

    // Reset while a word is being handed to the serializer.
    start_xfer(1'b1, 8, 1, 2, 0, 16'h0001, 1'b1, 0, 0);
    begin
      int n;
      n = 0;
      while (!phy_tx_valid_out && n < 50) begin
        tick();
        n++;
      end
      chk("t7_reached_push", int'(phy_tx_valid_out), 1);
    end
    reset = 1'b1;
    #1;
    chk("t7_rst_busy", int'(busy_out), 0);
    chk("t7_rst_txv", int'(phy_tx_valid_out), 0);
    chk("t7_rst_done", int'(done_out), 0);
    chk("t7_rst_pop", int'(fifo_read_en_out), 0);
    repeat (3) tick();
    chk("t7_no_done", tot_done - s_done, 0);
    reset = 1'b0;
    tick();
    start_xfer(1'b1, 8, 1, 2, 0, 16'h0001, 1'b1, 0, 0);
    wait_done(200);
    finish_xfer("t7b", 1'b1, 2, 1, 0);

`ifdef DAT_FIFO_CTRL_TIMEOUT_EN
    // No block-done: watchdog ends BLK_WAIT after 100 cycles.
    start_xfer(1'b1, 4, 1, 1, 0, 16'h0001, 1'b0, 0, 0);
    wait_done(400);
    chk("t8_wait_cycles", done_cyc - last_txv_cyc, TO + 1);
    finish_xfer("t8", 1'b1, 1, 0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
